uart_frame_decoder: RTL and testbench
=====================================

# uart_frame_decoder

Consumes the byte stream from the UART receiver (8-bit byte plus one-cycle ready pulse) and decodes fixed 4-byte register-write frames: sync, address, data, checksum. A frame that validates produces a one-cycle write strobe with the address and data. A bad checksum or an inter-byte gap timeout produces an error pulse and discards the frame. Sits directly downstream of the receiver, in the same bit-clock domain, and drives the register-bank write port.

## Interface
- SYNC, 8'hA5, frame start byte
- TIMEOUT, 200, max clk cycles between consecutive bytes of one frame (200 = 20 byte times); legal range 2..65535
- clk  input  1  bit clock, same clock as the receiver
- reset  input  1  synchronous, active-high
- in_data  input  8  received byte; bit ordering identical to the receiver's out port (index 0 = MSB)
- in_ready  input  1  one-cycle pulse: in_data valid this cycle
- wr_addr  output  8  address of last valid frame
- wr_data  output  8  data of last valid frame
- wr_strobe  output  1  one-cycle pulse: wr_addr/wr_data updated this cycle
- err_cksum  output  1  one-cycle pulse: checksum mismatch, frame dropped
- err_timeout  output  1  one-cycle pulse: inter-byte gap exceeded, frame dropped
- busy  output  1  high while a frame is partially received (state != IDLE)

## Operation
- Reset values: all outputs 0; state IDLE; timer 0; internal addr/data latches 0.
- States: IDLE, ADDR, DATA, CKSUM. Only cycles with in_ready=1 advance the state; in_data is ignored otherwise.
- IDLE: in_ready with in_data==SYNC -> ADDR. Any other byte is ignored, with no error.
- ADDR: latch in_data as the address -> DATA. A byte equal to SYNC here is treated as an address; there is no resync.
- DATA: latch in_data as the data -> CKSUM.
- CKSUM: expected value = addr XOR data XOR SYNC.
  - Match: register addr/data onto wr_addr/wr_data, pulse wr_strobe -> IDLE.
  - Mismatch: pulse err_cksum; wr_addr/wr_data unchanged -> IDLE.
- wr_addr/wr_data hold their values until the next valid frame.
- Timer:
  - Cleared on every accepted in_ready.
  - Counts each cycle while state != IDLE and in_ready=0.
  - Held at 0 in IDLE.
  - Expires on the cycle the count reaches TIMEOUT-1 with no in_ready. On expiry: pulse err_timeout, return to IDLE, discard latched addr/data.
- Simultaneous in_ready and timer expiry: the byte wins; no timeout is reported.
- A frame that completes leaves the block in IDLE. A SYNC arriving on the next in_ready starts a new frame. Back-to-back frames need no gap.
- Reset mid-frame: the next cycle is IDLE, all pulses are 0, and wr_addr/wr_data are cleared to 0.
- At most one of wr_strobe, err_cksum, err_timeout is high in any cycle.

## Timing
- All outputs are registered.
- wr_strobe / err_cksum are high exactly one cycle, in the cycle after the checksum byte's in_ready. wr_addr/wr_data are valid in that same cycle.
- err_timeout is high in the cycle after the expiry cycle. busy falls in that same cycle.
- busy rises the cycle after the SYNC in_ready and falls the cycle after the checksum in_ready or the expiry.
- Input contract: in_ready is never high on two consecutive cycles. The receiver guarantees a gap of ≥10 cycles. The block needs no back-pressure.
- Timer width: 16 bits, saturating; it never wraps.

## Structure
- Shared package uart_pkg contains:
  - state encoding typedef: IDLE=0, ADDR=1, DATA=2, CKSUM=3
  - default SYNC constant 8'hA5
  - a checksum function (a XOR d XOR sync), reused by a future frame encoder on the TX side
- One sub-module: uart_gap_timer.
  - Parameter TIMEOUT.
  - Inputs clk, reset, clear, run.
  - Output expired: a one-cycle pulse.
  - Instantiated once.
- FSM and output registers stay in uart_frame_decoder.

## Test plan
- Valid frame: bytes A5,12,34,(12^34^A5=83), spaced 10 cycles -> single wr_strobe, wr_addr=12, wr_data=34, no error pulses; busy low afterwards.
- Bad checksum: A5,12,34,00 -> err_cksum one cycle, no wr_strobe, wr_addr/wr_data keep their prior values.
- Idle noise: 00,FF,5A, then the valid frame A5,01,02,A6 -> only one wr_strobe (addr 01, data 02); the noise bytes produce nothing.
- Timeout: A5,12, then no bytes for 200 cycles -> err_timeout exactly 200 cycles after the 12 in_ready, busy drops. A following A5,01,02,A6 decodes normally.
- Boundary: a byte arriving exactly on the expiry cycle (199 cycles idle, then in_ready) -> no err_timeout; the frame continues and completes.
- Reset mid-frame: A5,12, assert reset 1 cycle, then 34,(checksum) -> no strobe, no error; all outputs 0 after reset. Then A5,AA,55,5A -> wr_strobe with wr_addr=AA, wr_data=55.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART frame path (RX decoder now, TX encoder later).
//   state_e        : decoder FSM state encoding (IDLE=0, ADDR=1, DATA=2, CKSUM=3)
//   SyncDefault    : default frame start byte
//   calc_cksum()   : frame checksum, addr ^ data ^ sync
package uart_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAddr  = 2'd1,
    StData  = 2'd2,
    StCksum = 2'd3
  } state_e;

  localparam logic [7:0] SyncDefault = 8'hA5;

  function automatic logic [7:0] calc_cksum(input logic [7:0] addr, input logic [7:0] data,
                                            input logic [7:0] sync);
    return addr ^ data ^ sync;
  endfunction

endpackage

// File: rtl/uart_gap_timer.sv
// Inter-byte gap timer for the frame decoder.
//   clk, reset : clock and synchronous active-high reset
//   clear      : force the count to zero (byte accepted, or decoder idle)
//   run        : count this cycle
//   expired    : one-cycle pulse on the cycle the count sits at TIMEOUT-1 while running
module uart_gap_timer #(
  parameter int unsigned TIMEOUT = 200
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam logic [15:0] Limit = 16'(TIMEOUT - 1);

  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = 16'd0;
    end else if (run && (count_q != 16'hFFFF)) begin
      // Saturate rather than wrap.
      count_d = count_q + 16'd1;
    end
  end

  // clear has priority: a byte arriving on the expiry cycle suppresses the timeout.
  assign expired = run && !clear && (count_q == Limit);

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= 16'd0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_frame_decoder.sv
// Decodes 4-byte register-write frames (sync, addr, data, checksum) from the UART
// receiver byte stream and drives the register-bank write port.
//   clk, reset   : bit clock, synchronous active-high reset
//   in_data      : received byte (index 0 = MSB), valid when in_ready
//   in_ready     : one-cycle byte-valid pulse
//   wr_addr/data : address/data of the last valid frame
//   wr_strobe    : one-cycle pulse, wr_addr/wr_data updated
//   err_cksum    : one-cycle pulse, checksum mismatch, frame dropped
//   err_timeout  : one-cycle pulse, inter-byte gap exceeded, frame dropped
//   busy         : frame partially received
module uart_frame_decoder
  import uart_pkg::*;
#(
  parameter logic [7:0]  SYNC    = SyncDefault,
  parameter int unsigned TIMEOUT = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [0:7] in_data,
  input  logic       in_ready,
  output logic [0:7] wr_addr,
  output logic [0:7] wr_data,
  output logic       wr_strobe,
  output logic       err_cksum,
  output logic       err_timeout,
  output logic       busy
);

  state_e     state_q, state_d;
  logic [0:7] addr_q, addr_d;
  logic [0:7] data_q, data_d;
  logic [0:7] wr_addr_q, wr_addr_d;
  logic [0:7] wr_data_q, wr_data_d;
  logic       wr_strobe_q, wr_strobe_d;
  logic       err_cksum_q, err_cksum_d;
  logic       err_timeout_q, err_timeout_d;
  logic       busy_q, busy_d;
  logic       timer_clear, timer_run, expired;

  assign timer_clear = in_ready || (state_q == StIdle);
  assign timer_run   = (state_q != StIdle) && !in_ready;

  uart_gap_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_gap_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .run    (timer_run),
    .expired(expired)
  );

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    data_d        = data_q;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    wr_strobe_d   = 1'b0;
    err_cksum_d   = 1'b0;
    err_timeout_d = 1'b0;
    if (in_ready) begin
      unique case (state_q)
        StIdle: begin
          if (in_data == SYNC) state_d = StAddr;
        end
        StAddr: begin
          addr_d  = in_data;
          state_d = StData;
        end
        StData: begin
          data_d  = in_data;
          state_d = StCksum;
        end
        StCksum: begin
          if (in_data == calc_cksum(addr_q, data_q, SYNC)) begin
            wr_addr_d   = addr_q;
            wr_data_d   = data_q;
            wr_strobe_d = 1'b1;
          end else begin
            err_cksum_d = 1'b1;
          end
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end else if (expired) begin
      err_timeout_d = 1'b1;
      state_d       = StIdle;
      addr_d        = '0;
      data_d        = '0;
    end
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      addr_q        <= '0;
      data_q        <= '0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      wr_strobe_q   <= 1'b0;
      err_cksum_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      wr_strobe_q   <= wr_strobe_d;
      err_cksum_q   <= err_cksum_d;
      err_timeout_q <= err_timeout_d;
      busy_q        <= busy_d;
    end
  end

  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign wr_strobe   = wr_strobe_q;
  assign err_cksum   = err_cksum_q;
  assign err_timeout = err_timeout_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Self-checking bench for uart_frame_decoder: directed test-plan steps followed by
// randomized frames, every cycle compared against a byte-list reference model.
module tb_uart_frame_decoder;

  localparam int TIMEOUT = 200;
  localparam logic [7:0] SYNC = 8'hA5;

  logic       clk = 1'b0;
  logic       reset;
  logic [0:7] in_data;
  logic       in_ready;
  logic [0:7] wr_addr, wr_data;
  logic       wr_strobe, err_cksum, err_timeout, busy;

  int checks = 0;
  int errors = 0;

  // Reference model: bytes collected so far in the current frame and idle cycles since
  // the last byte; expected outputs for the cycle after each clock edge.
  logic [7:0] frame [3];
  int         nbytes = 0;
  int         gap = 0;
  logic [7:0] e_addr = 8'h00, e_data = 8'h00;
  logic       e_strobe = 1'b0, e_cksum = 1'b0, e_tmo = 1'b0, e_busy = 1'b0;
  int         n_strobe = 0, n_cksum = 0, n_tmo = 0;

  always #5 clk = ~clk;

  uart_frame_decoder #(
    .SYNC   (SYNC),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_strobe  (wr_strobe),
    .err_cksum  (err_cksum),
    .err_timeout(err_timeout),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model(input logic r, input logic rdy, input logic [7:0] d);
    e_strobe = 1'b0;
    e_cksum  = 1'b0;
    e_tmo    = 1'b0;
    if (r) begin
      nbytes = 0;
      gap    = 0;
      e_addr = 8'h00;
      e_data = 8'h00;
    end else if (rdy) begin
      gap = 0;
      if (nbytes == 0) begin
        if (d == SYNC) begin
          frame[0] = d;
          nbytes   = 1;
        end
      end else if (nbytes < 3) begin
        frame[nbytes] = d;
        nbytes++;
      end else begin
        if (d == (frame[0] ^ frame[1] ^ frame[2])) begin
          e_strobe = 1'b1;
          e_addr   = frame[1];
          e_data   = frame[2];
        end else begin
          e_cksum = 1'b1;
        end
        nbytes = 0;
      end
    end else if (nbytes != 0) begin
      gap++;
      if (gap == TIMEOUT) begin
        e_tmo  = 1'b1;
        nbytes = 0;
        gap    = 0;
      end
    end
    e_busy = (nbytes != 0);
  endtask

  // One clock cycle: drive inputs, let the edge pass, compare all outputs 1 time unit later.
  task automatic step(input logic r, input logic rdy, input logic [7:0] d);
    reset    = r;
    in_ready = rdy;
    in_data  = d;
    @(posedge clk);
    model(r, rdy, d);
    #1;
    if (wr_strobe === 1'b1) n_strobe++;
    if (err_cksum === 1'b1) n_cksum++;
    if (err_timeout === 1'b1) n_tmo++;
    check("wr_addr", wr_addr, e_addr);
    check("wr_data", wr_data, e_data);
    check("wr_strobe", {7'd0, wr_strobe}, {7'd0, e_strobe});
    check("err_cksum", {7'd0, err_cksum}, {7'd0, e_cksum});
    check("err_timeout", {7'd0, err_timeout}, {7'd0, e_tmo});
    check("busy", {7'd0, busy}, {7'd0, e_busy});
  endtask

  task automatic send_byte(input logic [7:0] d, input int idle);
    step(1'b0, 1'b1, d);
    for (int i = 0; i < idle; i++) step(1'b0, 1'b0, 8'($urandom));
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] ck);
    send_byte(SYNC, 9);
    send_byte(a, 9);
    send_byte(d, 9);
    send_byte(ck, 9);
  endtask

  initial begin
    int tmo_at;
    int s0, c0, t0;
    reset    = 1'b1;
    in_ready = 1'b0;
    in_data  = 8'h00;

    // Reset state.
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    check("reset_busy", {7'd0, busy}, 8'd0);

    // Valid frame.
    s0 = n_strobe;
    send_frame(8'h12, 8'h34, 8'h83);
    check("valid_strobes", 8'(n_strobe - s0), 8'd1);
    check("valid_addr", wr_addr, 8'h12);
    check("valid_data", wr_data, 8'h34);

    // Bad checksum keeps prior write values.
    c0 = n_cksum;
    send_frame(8'h56, 8'h78, 8'h00);
    check("bad_cksum_pulses", 8'(n_cksum - c0), 8'd1);
    check("bad_keep_addr", wr_addr, 8'h12);

    // Idle noise, then a valid frame.
    s0 = n_strobe;
    c0 = n_cksum;
    send_byte(8'h00, 9);
    send_byte(8'hFF, 9);
    send_byte(8'h5A, 9);
    send_frame(8'h01, 8'h02, 8'hA6);
    check("noise_strobes", 8'(n_strobe - s0), 8'd1);
    check("noise_errs", 8'(n_cksum - c0), 8'd0);
    check("noise_addr", wr_addr, 8'h01);

    // Timeout latency measured from the address byte.
    send_byte(SYNC, 9);
    send_byte(8'h12, 0);
    tmo_at = -1;
    for (int k = 1; k <= 210; k++) begin
      step(1'b0, 1'b0, 8'h00);
      if (err_timeout === 1'b1 && tmo_at < 0) tmo_at = k;
    end
    check("timeout_latency", 8'(tmo_at), 8'd200);
    send_frame(8'h01, 8'h02, 8'hA6);
    check("after_tmo_data", wr_data, 8'h02);

    // Byte arriving exactly on the expiry cycle wins.
    t0 = n_tmo;
    s0 = n_strobe;
    send_byte(SYNC, 9);
    send_byte(8'h12, TIMEOUT - 1);
    send_byte(8'h34, 9);
    send_byte(8'h83, 9);
    check("boundary_no_tmo", 8'(n_tmo - t0), 8'd0);
    check("boundary_strobe", 8'(n_strobe - s0), 8'd1);

    // Reset mid-frame.
    s0 = n_strobe;
    c0 = n_cksum;
    send_byte(SYNC, 9);
    send_byte(8'h12, 3);
    step(1'b1, 1'b0, 8'h00);
    check("rst_mid_addr", wr_addr, 8'h00);
    check("rst_mid_busy", {7'd0, busy}, 8'd0);
    send_byte(8'h34, 9);
    send_byte(8'h83, 9);
    check("rst_mid_nothing", 8'(n_strobe - s0 + n_cksum - c0), 8'd0);
    send_frame(8'hAA, 8'h55, 8'h5A);
    check("rst_after_addr", wr_addr, 8'hAA);
    check("rst_after_data", wr_data, 8'h55);

    // Randomized frames: noise, bad checksums, and long gaps that may time out.
    for (int f = 0; f < 40; f++) begin
      logic [7:0] a, d, ck;
      int g;
      a  = 8'($urandom);
      d  = 8'($urandom);
      ck = a ^ d ^ SYNC;
      if ($urandom_range(0, 3) == 0) ck = ck ^ 8'(1 << $urandom_range(0, 7));
      if ($urandom_range(0, 4) == 0) send_byte(8'($urandom), $urandom_range(9, 20));
      send_byte(SYNC, $urandom_range(9, 30));
      send_byte(a, $urandom_range(9, 30));
      g = ($urandom_range(0, 5) == 0) ? $urandom_range(195, 205) : $urandom_range(9, 30);
      send_byte(d, g);
      send_byte(ck, $urandom_range(9, 30));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
